// File: rtl/video_daisy_avalon_ctrl_n.sv
// Avalon-MM configuration master that writes a bypass bit into each daisy-chained
// video core, one core at a time, on a debounced key press or a switch change.
module video_daisy_avalon_ctrl_n #(
   parameter int NUM_CORES       = 4,
   parameter int AW              = 2,
   parameter int DW              = 32,
   parameter int BYPASS_ADDR     = 0,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int AUTO_UPDATE     = 1
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic [NUM_CORES-1:0]    core_bypass,
   input  logic                    avalon_write_n,
   output logic [NUM_CORES*AW-1:0] avs_address,
   output logic [NUM_CORES-1:0]    avs_write,
   output logic [NUM_CORES*DW-1:0] avs_writedata,
   input  logic [NUM_CORES-1:0]    avs_waitrequest,
   output logic                    busy,
   output logic                    done
);

   localparam int IW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES);
   localparam int ATW = NUM_CORES * AW;
   localparam int DTW = NUM_CORES * DW;

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t                 state;
   logic [IW-1:0]          idx;
   logic [IW-1:0]          idx_nxt;
   logic                   pending;
   logic [NUM_CORES-1:0]   snapshot;

   logic                   key_s1, key_s2;
   logic [NUM_CORES-1:0]   sw_s1, sw_s2;
   logic [CW-1:0]          db_cnt;
   logic                   key_db;
   logic                   key_trig;
   logic                   sw_trig;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         key_s1 <= avalon_write_n;
         key_s2 <= key_s1;
         sw_s1  <= core_bypass;
         sw_s2  <= sw_s1;
      end
   end

   // The counter only runs while the synced key disagrees with the debounced level,
   // so any bounce back to the old level restarts the qualification window.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         db_cnt   <= '0;
         key_db   <= 1'b1;
         key_trig <= 1'b0;
      end else begin
         key_trig <= 1'b0;
         if (key_s2 == key_db) begin
            db_cnt <= '0;
         end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            key_db   <= key_s2;
            key_trig <= key_db & ~key_s2;
         end else begin
            db_cnt <= db_cnt + CW'(1);
         end
      end
   end

   assign sw_trig = (AUTO_UPDATE != 0) && (sw_s2 != snapshot) && (state == IDLE) && !pending;
   assign idx_nxt = idx + IW'(1);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state         <= IDLE;
         idx           <= '0;
         pending       <= 1'b0;
         snapshot      <= '0;
         avs_write     <= '0;
         avs_address   <= '0;
         avs_writedata <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         if (key_trig && (state != IDLE))
            pending <= 1'b1;
         case (state)
            IDLE: begin
               if (key_trig || sw_trig || pending) begin
                  state         <= WRITE;
                  busy          <= 1'b1;
                  idx           <= '0;
                  pending       <= 1'b0;
                  snapshot      <= sw_s2;
                  avs_write     <= NUM_CORES'(1);
                  avs_address   <= ATW'(AW'(BYPASS_ADDR));
                  avs_writedata <= DTW'(sw_s2[0]);
               end
            end
            WRITE: begin
               // A stalled core keeps every output frozen until it accepts.
               if (!avs_waitrequest[idx]) begin
                  avs_write     <= '0;
                  avs_address   <= '0;
                  avs_writedata <= '0;
                  if (idx == IW'(NUM_CORES - 1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     idx                               <= idx_nxt;
                     avs_write[idx_nxt]                <= 1'b1;
                     avs_address[idx_nxt*AW +: AW]     <= AW'(BYPASS_ADDR);
                     avs_writedata[idx_nxt*DW +: DW]   <= DW'(snapshot[idx_nxt]);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_daisy_avalon_ctrl_n.sv
// Scoreboard bench: instance A has AUTO_UPDATE=0, instance B has AUTO_UPDATE=1;
// stimulus pushes expected writes/done pulses, a negedge monitor pops and compares them.
module tb_video_daisy_avalon_ctrl_n;

   logic        clk = 1'b0;
   logic        rst;
   logic        keyA, keyB;
   logic [2:0]  swA, swB, waitA, waitB, wrA, wrB;
   logic [5:0]  addrA, addrB;
   logic [95:0] dataA, dataB;
   logic        busyA, busyB, doneA, doneB;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct packed {
      logic       isDone;
      logic [1:0] core;
      logic       data;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;

   video_daisy_avalon_ctrl_n #(
      .NUM_CORES(3), .AW(2), .DW(32), .BYPASS_ADDR(1), .DEBOUNCE_CYCLES(4), .AUTO_UPDATE(0)
   ) dutA (
      .sys_clk(clk), .sys_rst(rst), .core_bypass(swA), .avalon_write_n(keyA),
      .avs_address(addrA), .avs_write(wrA), .avs_writedata(dataA),
      .avs_waitrequest(waitA), .busy(busyA), .done(doneA)
   );

   video_daisy_avalon_ctrl_n #(
      .NUM_CORES(3), .AW(2), .DW(32), .BYPASS_ADDR(1), .DEBOUNCE_CYCLES(4), .AUTO_UPDATE(1)
   ) dutB (
      .sys_clk(clk), .sys_rst(rst), .core_bypass(swB), .avalon_write_n(keyB),
      .avs_address(addrB), .avs_write(wrB), .avs_writedata(dataB),
      .avs_waitrequest(waitB), .busy(busyB), .done(doneB)
   );

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      checkCount++;
      if (act === exp)
         passCount++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic failEvent(input string name, input logic [95:0] act);
      checkCount++;
      $display("[TB] FAIL %s: got %0h, expected nothing", name, act);
   endtask

   function automatic int qsize(input int inst);
      return (inst == 0) ? qa.size() : qb.size();
   endfunction

   function automatic exp_t qfront(input int inst);
      return (inst == 0) ? qa[0] : qb[0];
   endfunction

   task automatic qpop(input int inst);
      if (inst == 0) void'(qa.pop_front());
      else           void'(qb.pop_front());
   endtask

   task automatic pushPass(input int inst, input logic [2:0] sw);
      exp_t e;
      for (int c = 0; c < 3; c++) begin
         e.isDone = 1'b0;
         e.core   = 2'(c);
         e.data   = sw[c];
         if (inst == 0) qa.push_back(e);
         else           qb.push_back(e);
      end
      e = '{isDone: 1'b1, core: 2'd0, data: 1'b0};
      if (inst == 0) qa.push_back(e);
      else           qb.push_back(e);
   endtask

   task automatic monitorStep(input int inst, input logic [2:0] wr, input logic [5:0] addr,
                              input logic [95:0] data, input logic [2:0] wt,
                              input logic bs, input logic dn);
      exp_t        e;
      logic [5:0]  ea;
      logic [95:0] ed;
      if (dn) begin
         if (qsize(inst) == 0) begin
            failEvent($sformatf("unexpected_done_%0d", inst), 96'(dn));
         end else begin
            e = qfront(inst);
            checkOutput($sformatf("done_order_%0d", inst), 96'(e.isDone), 96'd1);
            if (e.isDone) qpop(inst);
         end
      end
      if (wr != 3'b000) begin
         if (qsize(inst) == 0) begin
            failEvent($sformatf("unexpected_write_%0d", inst), 96'(wr));
         end else begin
            e = qfront(inst);
            checkOutput($sformatf("write_order_%0d", inst), 96'(e.isDone), 96'd0);
            if (!e.isDone) begin
               ea = 6'b000001 << (e.core * 2);
               ed = 96'(e.data) << (e.core * 32);
               checkOutput($sformatf("avs_write_%0d", inst), 96'(wr), 96'(3'b001 << e.core));
               checkOutput($sformatf("avs_address_%0d", inst), 96'(addr), 96'(ea));
               checkOutput($sformatf("avs_writedata_%0d", inst), data, ed);
               checkOutput($sformatf("busy_in_write_%0d", inst), 96'(bs), 96'd1);
               if (!wt[e.core]) qpop(inst);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         monitorStep(0, wrA, addrA, dataA, waitA, busyA, doneA);
         monitorStep(1, wrB, addrB, dataB, waitB, busyB, doneB);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One full debounced press: held low long enough to qualify, then released.
   task automatic applyStimulus(input int inst);
      if (inst == 0) keyA = 1'b0; else keyB = 1'b0;
      tick(10);
      if (inst == 0) keyA = 1'b1; else keyB = 1'b1;
      tick(10);
   endtask

   task automatic waitWrite(input int inst, input int core);
      int n = 0;
      @(negedge clk);
      while (!((inst == 0) ? wrA[core] : wrB[core]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) failEvent($sformatf("timeout_write_%0d_core%0d", inst, core), 96'(n));
   endtask

   task automatic waitDrain(input int inst);
      int n = 0;
      while (qsize(inst) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) failEvent($sformatf("timeout_drain_%0d", inst), 96'(qsize(inst)));
      tick(2);
      checkOutput($sformatf("busy_idle_%0d", inst), 96'((inst == 0) ? busyA : busyB), 96'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1; keyA = 1'b1; keyB = 1'b1;
      swA = 3'b000; swB = 3'b000; waitA = 3'b000; waitB = 3'b000;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_wrA", 96'(wrA), 96'd0);
      checkOutput("reset_addrA", 96'(addrA), 96'd0);
      checkOutput("reset_dataA", dataA, 96'd0);
      checkOutput("reset_busyA", 96'(busyA), 96'd0);
      checkOutput("reset_doneA", 96'(doneA), 96'd0);
      checkOutput("reset_wrB", 96'(wrB), 96'd0);
      checkOutput("reset_busyB", 96'(busyB), 96'd0);

      $display("[TB] single pass, switches 101");
      @(posedge clk); #1;
      swA = 3'b101;
      tick(4);
      pushPass(0, 3'b101);
      applyStimulus(0);
      waitDrain(0);

      $display("[TB] short key glitches");
      for (int g = 0; g < 5; g++) begin
         keyA = 1'b0;
         tick(2);
         keyA = 1'b1;
         tick(3);
         checkOutput("glitch_busy", 96'(busyA), 96'd0);
      end
      tick(10);
      checkOutput("glitch_busy_after", 96'(busyA), 96'd0);

      $display("[TB] waitrequest stall on core1");
      waitA = 3'b010;
      swA = 3'b110;
      tick(3);
      pushPass(0, 3'b110);
      keyA = 1'b0;
      waitWrite(0, 1);
      for (int k = 0; k < 7; k++) begin
         checkOutput("stall_wr", 96'(wrA), 96'(3'b010));
         checkOutput("stall_data", dataA, 96'h1 << 32);
         if (k < 6) @(negedge clk);
      end
      @(posedge clk); #1;
      waitA = 3'b000;
      @(negedge clk);
      checkOutput("stall_last_cycle", 96'(wrA), 96'(3'b010));
      @(negedge clk);
      checkOutput("core2_after_stall", 96'(wrA), 96'(3'b100));
      @(posedge clk); #1;
      keyA = 1'b1;
      tick(10);
      waitDrain(0);

      $display("[TB] presses during a running pass coalesce");
      swA = 3'b011;
      waitA = 3'b010;
      tick(3);
      pushPass(0, 3'b011);
      applyStimulus(0);
      swA = 3'b100;
      pushPass(0, 3'b100);
      applyStimulus(0);
      applyStimulus(0);
      checkOutput("still_stalled", 96'(wrA), 96'(3'b010));
      waitA = 3'b000;
      waitDrain(0);
      tick(20);
      checkOutput("no_third_pass", 96'(busyA), 96'd0);

      $display("[TB] auto update on switch change");
      waitB = 3'b010;
      pushPass(1, 3'b010);
      swB = 3'b010;
      waitWrite(1, 1);
      @(posedge clk); #1;
      swB = 3'b110;
      pushPass(1, 3'b110);
      tick(5);
      checkOutput("inflight_data", dataB, 96'h1 << 32);
      waitB = 3'b000;
      waitDrain(1);

      $display("[TB] reset during core1 write");
      waitA = 3'b010;
      swA = 3'b011;
      tick(3);
      pushPass(0, 3'b011);
      applyStimulus(0);
      applyStimulus(0);
      checkOutput("queue_before_reset", 96'(qa.size()), 96'd3);
      checkOutput("stalled_before_reset", 96'(wrA), 96'(3'b010));
      pushPass(1, 3'b110);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      qa.delete();
      @(negedge clk);
      checkOutput("rst_wrA", 96'(wrA), 96'd0);
      checkOutput("rst_addrA", 96'(addrA), 96'd0);
      checkOutput("rst_dataA", dataA, 96'd0);
      checkOutput("rst_busyA", 96'(busyA), 96'd0);
      checkOutput("rst_doneA", 96'(doneA), 96'd0);
      @(posedge clk); #1;
      waitA = 3'b000;
      waitDrain(1);
      tick(20);
      checkOutput("pending_lost_busyA", 96'(busyA), 96'd0);

      tick(5);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
